// File: rtl/score_tracker_pkg.sv
// Shared constants for score_tracker: grade encodings, point values,
// accuracy scale and rank thresholds, plus small lookup helpers.
package score_tracker_pkg;

   typedef logic [1:0] grade_t;

   localparam grade_t GRADE_PERFECT = 2'd3;
   localparam grade_t GRADE_GREAT   = 2'd2;
   localparam grade_t GRADE_GOOD    = 2'd1;
   localparam grade_t GRADE_MISS    = 2'd0;

   localparam logic [8:0] PTS_PERFECT = 9'd300;
   localparam logic [8:0] PTS_GREAT   = 9'd100;
   localparam logic [8:0] PTS_GOOD    = 9'd50;

   localparam int QUO_W = 14;
   localparam int DVD_W = 48;
   localparam int DSR_W = 32;

   localparam logic [QUO_W-1:0] ACC_FULL = 14'd10000;
   localparam logic [QUO_W-1:0] ACC_LV5  = 14'd9500;
   localparam logic [QUO_W-1:0] ACC_LV4  = 14'd9000;
   localparam logic [QUO_W-1:0] ACC_LV3  = 14'd8000;
   localparam logic [QUO_W-1:0] ACC_LV2  = 14'd7000;
   localparam logic [QUO_W-1:0] ACC_LV1  = 14'd6000;

   function automatic logic [8:0] grade_points(input grade_t g);
      logic [8:0] p;
      case (g)
         GRADE_PERFECT: p = PTS_PERFECT;
         GRADE_GREAT:   p = PTS_GREAT;
         GRADE_GOOD:    p = PTS_GOOD;
         default:       p = 9'd0;
      endcase
      return p;
   endfunction

   function automatic logic [2:0] acc_level(input logic [QUO_W-1:0] a);
      logic [2:0] lv;
      if (a >= ACC_FULL)     lv = 3'd6;
      else if (a >= ACC_LV5) lv = 3'd5;
      else if (a >= ACC_LV4) lv = 3'd4;
      else if (a >= ACC_LV3) lv = 3'd3;
      else if (a >= ACC_LV2) lv = 3'd2;
      else if (a >= ACC_LV1) lv = 3'd1;
      else                   lv = 3'd0;
      return lv;
   endfunction

endpackage

// File: rtl/score_tracker_if.sv
// Judgment handshake between the note judge (master) and score_tracker (slave).
interface score_tracker_if;
   logic       hit_valid;
   logic [1:0] hit_grade;
   logic       hit_ready;
   logic [1:0] mod;
   logic [3:0] difficulty;

   modport master (output hit_valid, hit_grade, mod, difficulty, input hit_ready);
   modport slave  (input hit_valid, hit_grade, mod, difficulty, output hit_ready);
endinterface

// File: rtl/score_tracker_acc_divider.sv
// acc_divider: iterative restoring divider, one quotient bit per cycle (MSB first),
// 14 cycles per division, with synchronous abort.
module score_tracker_acc_divider
   import score_tracker_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_abort,
   input  logic             i_start,
   input  logic [DVD_W-1:0] i_dividend,
   input  logic [DSR_W-1:0] i_divisor,
   output logic [QUO_W-1:0] o_quotient,
   output logic             o_busy,
   output logic             o_done
);

   logic             r_busy;
   logic [3:0]       r_cnt;
   logic [DVD_W-1:0] r_rem;
   logic [DVD_W-1:0] r_dsr;
   logic [QUO_W-1:0] r_quo;
   logic             r_ovf;
   logic             w_ge;
   logic             w_last;

   assign w_ge   = (r_rem >= r_dsr);
   assign w_last = (r_cnt == 4'(QUO_W-1));

   always_ff @(posedge clk) begin
      if (rst || i_abort) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
      end else if (i_start) begin
         r_busy <= 1'b1;
         r_cnt  <= '0;
      end else if (r_busy) begin
         if (w_last) r_busy <= 1'b0;
         r_cnt <= r_cnt + 4'd1;
      end
   end

   // A quotient that cannot fit in 14 bits is flagged up front and saturates.
   always_ff @(posedge clk) begin
      if (i_start) begin
         r_rem <= i_dividend;
         r_dsr <= DVD_W'(i_divisor) << (QUO_W-1);
         r_quo <= '0;
         r_ovf <= (i_dividend >= (DVD_W'(i_divisor) << QUO_W));
      end else if (r_busy) begin
         if (w_ge) r_rem <= r_rem - r_dsr;
         r_dsr <= r_dsr >> 1;
         r_quo <= {r_quo[QUO_W-2:0], w_ge};
      end
   end

   assign o_quotient = r_ovf ? '1 : r_quo;
   assign o_busy     = r_busy;
   assign o_done     = r_busy && w_last;

endmodule

// File: rtl/score_tracker.sv
// score_tracker: per-judgment combo/score/bonus accumulation and accuracy/rank.
// Optional macro SCORE_TRACKER_MAX_COMBO_EN adds the max_combo output.
module score_tracker
   import score_tracker_pkg::*;
#(
   parameter int STAT_W   = 21,
   parameter int COMBO_TH = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   score_tracker_if.slave    hit,
   output logic [STAT_W-1:0] combo,
   output logic [STAT_W-1:0] base_score,
   output logic [STAT_W-1:0] bonus_score,
   output logic [STAT_W-1:0] acc,
   output logic [2:0]        level
`ifdef SCORE_TRACKER_MAX_COMBO_EN
   ,
   output logic [STAT_W-1:0] max_combo
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PREP = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                 input logic [STAT_W-1:0] b);
      logic [STAT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[STAT_W] ? '1 : s[STAT_W-1:0];
   endfunction

   logic [1:0]        r_state;
   logic [STAT_W-1:0] r_combo;
   logic [STAT_W-1:0] r_base;
   logic [STAT_W-1:0] r_bonus;
   logic [STAT_W-1:0] r_acc;
   logic [2:0]        r_level;
   logic [31:0]       r_pts_sum;
   logic [STAT_W-1:0] r_hit_count;

   logic              w_accept;
   logic [8:0]        w_pts;
   logic [4:0]        w_mult;
   logic [13:0]       w_base_prod;
   logic [9:0]        w_bonus_pts;
   logic [STAT_W-1:0] w_combo_new;
   logic [DVD_W-1:0]  w_dividend;
   logic [DSR_W-1:0]  w_divisor;
   logic [QUO_W-1:0]  w_quo;
   logic [QUO_W-1:0]  w_quo_clamped;
   logic              w_div_busy;
   logic              w_div_done;

   assign hit.hit_ready = (r_state == S_IDLE);
   assign w_accept      = hit.hit_valid && (r_state == S_IDLE);

   assign w_pts       = grade_points(hit.hit_grade);
   assign w_mult      = {1'b0, hit.difficulty} + 5'd1;
   assign w_base_prod = {5'b0, w_pts} * {9'b0, w_mult};
   assign w_bonus_pts = 10'(w_pts[8:2]) << hit.mod;
   assign w_combo_new = (hit.hit_grade == GRADE_MISS) ? '0
                                                      : sat_add(r_combo, STAT_W'(1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_combo     <= '0;
         r_base      <= '0;
         r_bonus     <= '0;
         r_pts_sum   <= '0;
         r_hit_count <= '0;
      end else if (w_accept) begin
         r_combo     <= w_combo_new;
         r_base      <= sat_add(r_base, STAT_W'(w_base_prod));
         if (w_combo_new >= STAT_W'(COMBO_TH))
            r_bonus  <= sat_add(r_bonus, STAT_W'(w_bonus_pts));
         r_pts_sum   <= r_pts_sum + 32'(w_pts);
         r_hit_count <= sat_add(r_hit_count, STAT_W'(1));
      end
   end

`ifdef SCORE_TRACKER_MAX_COMBO_EN
   logic [STAT_W-1:0] r_max_combo;

   always_ff @(posedge clk) begin
      if (rst || clear)
         r_max_combo <= '0;
      else if (w_accept && (w_combo_new > r_max_combo))
         r_max_combo <= w_combo_new;
   end

   assign max_combo = r_max_combo;
`endif

   // PREP: operands are formed from the freshly updated accumulators.
   assign w_dividend    = {16'b0, r_pts_sum} * 48'd10000;
   assign w_divisor     = 32'(r_hit_count) * 32'd300;
   assign w_quo_clamped = (w_quo > ACC_FULL) ? ACC_FULL : w_quo;

   score_tracker_acc_divider u_div (
      .clk        (clk),
      .rst        (rst),
      .i_abort    (clear),
      .i_start    (r_state == S_PREP),
      .i_dividend (w_dividend),
      .i_divisor  (w_divisor),
      .o_quotient (w_quo),
      .o_busy     (w_div_busy),
      .o_done     (w_div_done)
   );

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_level <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) r_state <= S_PREP;
            S_PREP: r_state <= S_DIV;
            S_DIV:  if (w_div_done || !w_div_busy) r_state <= S_DONE;
            default: begin
               r_acc   <= STAT_W'(w_quo_clamped);
               r_level <= acc_level(w_quo_clamped);
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign combo       = r_combo;
   assign base_score  = r_base;
   assign bonus_score = r_bonus;
   assign acc         = r_acc;
   assign level       = r_level;

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker (optionally with SCORE_TRACKER_MAX_COMBO_EN).
module tb_score_tracker;
   import score_tracker_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic [20:0] combo, base_score, bonus_score, acc;
   logic [2:0]  level;
`ifdef SCORE_TRACKER_MAX_COMBO_EN
   logic [20:0] max_combo;
`endif

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   score_tracker_if hif ();

   score_tracker #(.STAT_W(21), .COMBO_TH(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .hit         (hif),
      .combo       (combo),
      .base_score  (base_score),
      .bonus_score (bonus_score),
      .acc         (acc),
      .level       (level)
`ifdef SCORE_TRACKER_MAX_COMBO_EN
      ,
      .max_combo   (max_combo)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (hif.hit_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_vec++;
         n_miss++;
         $display("FAIL %s: hit_ready never rose within 100 cycles", tag);
      end
   endtask

   task automatic do_hit(input grade_t g, input logic [3:0] d, input logic [1:0] m);
      wait_ready("hit_ready_wait");
      hif.hit_valid  = 1'b1;
      hif.hit_grade  = g;
      hif.difficulty = d;
      hif.mod        = m;
      @(posedge clk);
      #1;
      hif.hit_valid = 1'b0;
   endtask

   task automatic hit_wait(input grade_t g, input logic [3:0] d, input logic [1:0] m);
      do_hit(g, d, m);
      @(negedge clk);
      wait_ready("acc_update_wait");
   endtask

   task automatic clear_pulse();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      int n_busy;
      int t_prev;
      int t_now;
      int n;

      rst = 1'b1;
      clear = 1'b0;
      hif.hit_valid  = 1'b0;
      hif.hit_grade  = GRADE_MISS;
      hif.difficulty = 4'd0;
      hif.mod        = 2'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check_vec("rst_combo", combo, 0);
      check_vec("rst_base", base_score, 0);
      check_vec("rst_bonus", bonus_score, 0);
      check_vec("rst_acc", acc, 0);
      check_vec("rst_level", level, 0);
      check_vec("rst_ready", hif.hit_ready, 1);

      // single PERFECT, difficulty 0
      do_hit(GRADE_PERFECT, 4'd0, 2'd0);
      check_vec("one_combo", combo, 1);
      check_vec("one_base", base_score, 300);
      check_vec("one_bonus", bonus_score, 0);
      n_busy = 0;
      forever begin
         @(negedge clk);
         if (hif.hit_ready === 1'b1 || n_busy >= 40) break;
         n_busy++;
      end
      check_vec("one_busy_cycles", n_busy, 16);
      check_vec("one_acc", acc, 10000);
      check_vec("one_level", level, 6);

      // ten PERFECT hits, difficulty 1, mod 2
      clear_pulse();
      check_vec("clr_combo", combo, 0);
      check_vec("clr_acc", acc, 0);
      for (int i = 0; i < 10; i++) begin
         hit_wait(GRADE_PERFECT, 4'd1, 2'd2);
         if (i == 8) check_vec("ten_bonus_at9", bonus_score, 0);
      end
      check_vec("ten_base", base_score, 6000);
      check_vec("ten_combo", combo, 10);
      check_vec("ten_bonus", bonus_score, 300);
      check_vec("ten_acc", acc, 10000);
      check_vec("ten_level", level, 6);

      // PERFECT, GREAT, GOOD, MISS
      clear_pulse();
      hit_wait(GRADE_PERFECT, 4'd0, 2'd0);
      hit_wait(GRADE_GREAT, 4'd0, 2'd0);
      check_vec("mix2_acc", acc, 6666);
      check_vec("mix2_level", level, 1);
      hit_wait(GRADE_GOOD, 4'd0, 2'd0);
      check_vec("mix3_acc", acc, 5000);
      check_vec("mix3_level", level, 0);
      hit_wait(GRADE_MISS, 4'd0, 2'd0);
      check_vec("mix_combo", combo, 0);
      check_vec("mix_base", base_score, 450);
      check_vec("mix_bonus", bonus_score, 0);
      check_vec("mix_acc", acc, 3750);
      check_vec("mix_level", level, 0);
`ifdef SCORE_TRACKER_MAX_COMBO_EN
      check_vec("mix_max_combo", max_combo, 3);
`endif

      // continuous hit_valid, alternating PERFECT/MISS
      clear_pulse();
      hif.hit_valid  = 1'b1;
      hif.hit_grade  = GRADE_PERFECT;
      hif.difficulty = 4'd0;
      hif.mod        = 2'd0;
      t_prev = 0;
      for (int k = 0; k < 6; k++) begin
         n = 0;
         while (hif.hit_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (n >= 100) begin
            n_vec++;
            n_miss++;
            $display("FAIL stream_wait: hit_ready never rose within 100 cycles");
         end
         t_now = cyc;
         if (k > 0) check_vec("stream_gap", t_now - t_prev, 17);
         t_prev = t_now;
         @(posedge clk);
         #1;
         hif.hit_grade = (k % 2 == 0) ? GRADE_MISS : GRADE_PERFECT;
      end
      hif.hit_valid = 1'b0;
      @(negedge clk);
      wait_ready("stream_end_wait");
      check_vec("stream_combo", combo, 0);
      check_vec("stream_base", base_score, 900);
      check_vec("stream_acc", acc, 5000);

      // clear while dividing after the third hit
      clear_pulse();
      hit_wait(GRADE_PERFECT, 4'd0, 2'd0);
      hit_wait(GRADE_PERFECT, 4'd0, 2'd0);
      do_hit(GRADE_PERFECT, 4'd0, 2'd0);
      repeat (5) @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check_vec("abort_combo", combo, 0);
      check_vec("abort_base", base_score, 0);
      check_vec("abort_bonus", bonus_score, 0);
      check_vec("abort_acc", acc, 0);
      check_vec("abort_level", level, 0);
      check_vec("abort_ready", hif.hit_ready, 1);
      repeat (20) @(negedge clk);
      check_vec("abort_acc_late", acc, 0);
      check_vec("abort_level_late", level, 0);

      // base_score saturation at difficulty 15 (4800 points per PERFECT)
      clear_pulse();
      for (int i = 0; i < 438; i++) begin
         do_hit(GRADE_PERFECT, 4'd15, 2'd0);
         if (i == 435) check_vec("sat_base_436", base_score, 2092800);
         if (i == 436) check_vec("sat_base_437", base_score, 2097151);
      end
      @(negedge clk);
      wait_ready("sat_end_wait");
      check_vec("sat_base_hold", base_score, 2097151);
      check_vec("sat_combo", combo, 438);
      check_vec("sat_bonus", bonus_score, 32175);
      check_vec("sat_acc", acc, 10000);
      check_vec("sat_level", level, 6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/score_tracker.md
Name: score_tracker

Overview:
- Upstream of the scoreboard display: converts per-note hit judgments into running combo, base score, bonus score, accuracy and rank level, presented as stable registers the scoreboard multiplexes onto its tubes.
- Accepts one judgment at a time over a valid/ready handshake.
- Recomputes accuracy with an iterative 14-bit restoring divider; new hits are back-pressured while the divider runs.

Parameters:
- STAT_W, 21, width of combo/base_score/bonus_score/acc outputs; saturation ceiling is 2^STAT_W-1.
- COMBO_TH, 10, combo value at or above which bonus points accrue.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- clear  in  1  synchronous song restart; zeroes all statistics and aborts any division.
- hit_valid  in  1  judgment present.
- hit_grade  in  2  judgment: 3=PERFECT, 2=GREAT, 1=GOOD, 0=MISS.
- hit_ready  out  1  high when a judgment can be accepted.
- mod  in  2  bonus modifier, sampled at accept.
- difficulty  in  4  score multiplier index, sampled at accept.
- combo  out  STAT_W  current consecutive non-miss count.
- base_score  out  STAT_W  accumulated base points.
- bonus_score  out  STAT_W  accumulated bonus points.
- acc  out  STAT_W  accuracy in hundredths of a percent, 0..10000.
- level  out  3  rank 0..6 derived from acc.

Behaviour:
- Reset or clear: all outputs 0, hit_ready=1, internal pts_sum=0, hit_count=0, FSM to IDLE. rst and clear take priority over everything; a division in progress is discarded and acc/level keep their reset values.
- Accept occurs on a clk edge with hit_valid && hit_ready.
- Grade points: 300/100/50/0 for PERFECT/GREAT/GOOD/MISS.
- Cycle after accept (1-cycle latency):
  - combo = MISS ? 0 : combo+1.
  - base_score += points*(difficulty+1).
  - Bonus: if combo_new>=COMBO_TH, bonus_score += (points>>2)<<mod; otherwise no bonus.
  - pts_sum (32b) += points; hit_count (STAT_W) += 1.
- Saturation: combo, base_score, bonus_score and hit_count saturate at 2^STAT_W-1 and never wrap.
- FSM states and transitions:
  - IDLE --accept--> PREP.
  - PREP, 1 cycle: dividend = pts_sum*10000; divisor = hit_count*300.
  - DIV, 14 cycles: one quotient bit per cycle, MSB first.
  - DONE, 1 cycle: acc = quotient clamped to 10000; level updated; back to IDLE.
- hit_ready=1 only in IDLE, so acc and level update 16 cycles after accept.
- Outputs other than acc and level are not affected by the divider.
- Level thresholds (all from the new acc):

  | acc        | level |
  |------------|-------|
  | 10000      | 6     |
  | >=9500     | 5     |
  | >=9000     | 4     |
  | >=8000     | 3     |
  | >=7000     | 2     |
  | >=6000     | 1     |
  | else       | 0     |

- Divisor is never 0 in PREP, because hit_count>=1 after an accept.
- hit_valid while hit_ready=0: the judgment is not consumed; upstream must hold it.

Optional Feature:
- Macro SCORE_TRACKER_MAX_COMBO_EN.
- Defined: adds output max_combo [STAT_W-1:0], reset/clear to 0, updated the same cycle as combo to max(max_combo, combo_new).
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared constants header, existing constants file:
  - grade encodings GRADE_PERFECT/GREAT/GOOD/MISS;
  - point values PTS_PERFECT=300, PTS_GREAT=100, PTS_GOOD=50;
  - ACC_FULL=10000;
  - level thresholds ACC_LV5..ACC_LV1.
- One sub-module: acc_divider.
  - Inputs: start, 48-bit dividend, 32-bit divisor.
  - Outputs: 14-bit quotient, busy, done; synchronous abort input.
  - Owns the DIV state.
- score_tracker owns the handshake, the accumulators and level mapping.

Test Plan:
- Reset, then one PERFECT with difficulty=0, mod=0 -> next cycle combo=1, base_score=300, bonus_score=0; hit_ready low 16 cycles; then acc=10000, level=6.
- 10 PERFECT hits with difficulty=1, mod=2 -> base_score=6000, combo=10, bonus_score=300 (only the 10th hit: 75<<2), acc=10000.
- PERFECT, GREAT, GOOD, MISS in sequence -> combo=0, base_score=450, pts_sum=450, acc=450*10000/1200=3750, level=0.
- Assert hit_valid continuously with alternating PERFECT/MISS -> exactly one accept per 17 cycles; no judgment lost or double counted.
- Assert clear during DIV after 3 hits -> all outputs 0 next cycle, hit_ready=1, no later acc write.
- Preload base_score near 2^21-1 (via repeated hits at difficulty=15) -> base_score holds at 2097151 and does not wrap.
